// File: rtl/lvdc_mem_pkg.sv
// Shared types and helpers for the LVDC core-memory cycle scheduler:
// cycle states, requester ids, module-pair selects and odd parity.
package lvdc_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

  localparam logic [3:0] PAIR_01 = 4'b0001;
  localparam logic [3:0] PAIR_23 = 4'b0010;
  localparam logic [3:0] PAIR_45 = 4'b0100;
  localparam logic [3:0] PAIR_67 = 4'b1000;

  // Callers zero-extend their data word; padding zeros do not change the XOR.
  localparam int PARITY_MAX_W = 64;

  function automatic logic odd_parity(input logic [PARITY_MAX_W-1:0] data);
    return ~^data;
  endfunction

  function automatic logic [3:0] pair_onehot(input logic [1:0] pair);
    case (pair)
      2'd0:    return PAIR_01;
      2'd1:    return PAIR_23;
      2'd2:    return PAIR_45;
      default: return PAIR_67;
    endcase
  endfunction

endpackage

// File: rtl/lvdc_mem_dup_check.sv
// Parity check of the A/B read words and selection of the copy to return
// and regenerate; purely combinational.
module lvdc_mem_dup_check
  import lvdc_mem_pkg::*;
#(
  parameter int DATA_W = 26
) (
  input  logic [DATA_W:0]   rda,
  input  logic [DATA_W:0]   rdb,
  input  logic              sel_a,
  input  logic              sel_b,
  input  logic              duplex,
  output logic [DATA_W-1:0] word,
  output logic              err_a,
  output logic              err_b,
  output logic              fatal
);

  logic good_a;
  logic good_b;

  // A stored word is good when its 27 bits hold an odd number of ones.
  assign good_a = ^rda;
  assign good_b = ^rdb;
  assign err_a  = sel_a & ~good_a;
  assign err_b  = sel_b & ~good_b;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    word  = rda[DATA_W-1:0];
    fatal = 1'b0;
    if (duplex) begin
      if (good_a) begin
        word = rda[DATA_W-1:0];
      end else if (good_b) begin
        word = rdb[DATA_W-1:0];
      end else begin
        fatal = 1'b1;
      end
    end else if (sel_b) begin
      word  = rdb[DATA_W-1:0];
      fatal = ~good_b;
    end else begin
      fatal = ~good_a;
    end
  end

endmodule

// File: rtl/lvdc_mem_cycle_sched.sv
// Core-memory cycle scheduler: arbitrates instruction/data requesters and runs
// select, destructive read and write/regenerate with duplex parity recovery.
module lvdc_mem_cycle_sched
  import lvdc_mem_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 26,
  parameter int READ_CYC  = 2,
  parameter int WRITE_CYC = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IREQ,
  input  logic [2:0]        IMOD,
  input  logic              IDUPLEX,
  input  logic [ADDR_W-1:0] IADDR,
  input  logic              DREQ,
  input  logic [2:0]        DMOD,
  input  logic              DDUPLEX,
  input  logic [ADDR_W-1:0] DADDR,
  input  logic              DWE,
  input  logic [DATA_W-1:0] DWDATA,
  output logic              IACK,
  output logic              DACK,
  output logic [DATA_W-1:0] RDATA,
  output logic [3:0]        MPAIR,
  output logic              MSELA,
  output logic              MSELB,
  output logic [ADDR_W-1:0] MADDR,
  output logic              MRD,
  output logic              MWR,
  output logic [DATA_W:0]   MWDATA,
  input  logic [DATA_W:0]   MRDA,
  input  logic [DATA_W:0]   MRDB,
  output logic              ERRA,
  output logic              ERRB,
  output logic              FATAL
);

  localparam int MAX_CYC = (READ_CYC > WRITE_CYC) ? READ_CYC : WRITE_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  req_id_t           id_q;
  req_id_t           last_q;
  logic [2:0]        mod_q;
  logic              dup_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_word_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_a_q;
  logic              err_b_q;
  logic              fatal_q;

  logic              grant;
  logic              grant_i;
  logic              active;
  logic              sel_a;
  logic              sel_b;
  logic              read_last;
  logic              write_last;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] chk_word;
  logic              chk_err_a;
  logic              chk_err_b;
  logic              chk_fatal;

  // On a tie the requester served last loses, so the two alternate.
  assign grant      = (state == ST_IDLE) && (IREQ || DREQ);
  assign grant_i    = IREQ && (!DREQ || (last_q == REQ_D));
  assign read_last  = (state == ST_READ)  && (cnt == CNT_W'(READ_CYC - 1));
  assign write_last = (state == ST_WRITE) && (cnt == CNT_W'(WRITE_CYC - 1));
  assign active     = (state != ST_IDLE);
  assign sel_a      = dup_q || !mod_q[0];
  assign sel_b      = dup_q || mod_q[0];
  assign wr_data    = we_q ? wdata_q : rd_word_q;

  lvdc_mem_dup_check #(
    .DATA_W (DATA_W)
  ) u_dup_check (
    .rda    (MRDA),
    .rdb    (MRDB),
    .sel_a  (sel_a),
    .sel_b  (sel_b),
    .duplex (dup_q),
    .word   (chk_word),
    .err_a  (chk_err_a),
    .err_b  (chk_err_b),
    .fatal  (chk_fatal)
  );

  always_comb begin
    state_nxt = state;
    MPAIR     = '0;
    MSELA     = 1'b0;
    MSELB     = 1'b0;
    MADDR     = '0;
    MRD       = 1'b0;
    MWR       = 1'b0;
    MWDATA    = '0;
    IACK      = 1'b0;
    DACK      = 1'b0;
    if (active) begin
      MPAIR = pair_onehot(mod_q[2:1]);
      MSELA = sel_a;
      MSELB = sel_b;
      MADDR = addr_q;
    end
    case (state)
      ST_IDLE:  if (IREQ || DREQ) state_nxt = ST_SEL;
      ST_SEL:   state_nxt = ST_READ;
      ST_READ: begin
        MRD = 1'b1;
        if (read_last) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        MWR    = 1'b1;
        MWDATA = {odd_parity(PARITY_MAX_W'(wr_data)), wr_data};
        if (write_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        IACK      = (id_q == REQ_I);
        DACK      = (id_q == REQ_D);
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (RESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      last_q  <= REQ_D;
      rdata_q <= '0;
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == state) && ((state == ST_READ) || (state == ST_WRITE))) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      // Error flags appear on the first WRITE cycle; FATAL is sticky.
      err_a_q <= read_last && chk_err_a;
      err_b_q <= read_last && chk_err_b;
      if (read_last && chk_fatal) fatal_q <= 1'b1;
      if (write_last && !we_q)    rdata_q <= rd_word_q;
      if (state == ST_DONE)       last_q  <= id_q;
    end
  end

  // NOTE: the request latches and read word have no reset; every output that
  // exposes them is gated by state, which is reset.
  always_ff @(posedge CLK) begin
    if (grant) begin
      id_q    <= grant_i ? REQ_I : REQ_D;
      mod_q   <= grant_i ? IMOD : DMOD;
      dup_q   <= grant_i ? IDUPLEX : DDUPLEX;
      addr_q  <= grant_i ? IADDR : DADDR;
      we_q    <= !grant_i && DWE;
      wdata_q <= DWDATA;
    end
    if (read_last) rd_word_q <= chk_word;
  end

  assign RDATA = rdata_q;
  assign ERRA  = err_a_q;
  assign ERRB  = err_b_q;
  assign FATAL = fatal_q;

endmodule

// File: tb/tb_lvdc_mem_cycle_sched.sv
// Self-checking bench for lvdc_mem_cycle_sched: directed and random memory
// cycles compared against a transaction-level model of the scheduler.
`timescale 1ns/1ps
module tb_lvdc_mem_cycle_sched;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 26;
  localparam int READ_CYC  = 2;
  localparam int WRITE_CYC = 2;
  localparam int LAT       = READ_CYC + WRITE_CYC + 2;
  localparam int PERIOD    = LAT + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              ireq, iduplex, dreq, dduplex, dwe;
  logic [2:0]        imod, dmod;
  logic [ADDR_W-1:0] iaddr, daddr, maddr;
  logic [DATA_W-1:0] dwdata, rdata;
  logic              iack, dack, msela, mselb, mrd, mwr, erra, errb, fatal;
  logic [3:0]        mpair;
  logic [DATA_W:0]   mwdata, mrda, mrdb;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] m_rdata;
  logic              m_fatal;

  always #5 clk = ~clk;

  lvdc_mem_cycle_sched #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .READ_CYC  (READ_CYC),
    .WRITE_CYC (WRITE_CYC)
  ) dut (
    .CLK     (clk),
    .RESET   (reset),
    .IREQ    (ireq),
    .IMOD    (imod),
    .IDUPLEX (iduplex),
    .IADDR   (iaddr),
    .DREQ    (dreq),
    .DMOD    (dmod),
    .DDUPLEX (dduplex),
    .DADDR   (daddr),
    .DWE     (dwe),
    .DWDATA  (dwdata),
    .IACK    (iack),
    .DACK    (dack),
    .RDATA   (rdata),
    .MPAIR   (mpair),
    .MSELA   (msela),
    .MSELB   (mselb),
    .MADDR   (maddr),
    .MRD     (mrd),
    .MWR     (mwr),
    .MWDATA  (mwdata),
    .MRDA    (mrda),
    .MRDB    (mrdb),
    .ERRA    (erra),
    .ERRB    (errb),
    .FATAL   (fatal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build a stored word with correct odd parity, optionally corrupted.
  function automatic logic [DATA_W:0] mk_word(input logic [DATA_W-1:0] d, input logic bad);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {p ^ bad, d};
  endfunction

  function automatic logic is_good(input logic [DATA_W:0] w);
    return (($countones(w) % 2) == 1);
  endfunction

  // Starts at a negedge with the scheduler idle; ends one idle cycle after the ACK.
  task automatic run_txn(input logic is_i, input logic [2:0] mod, input logic dup,
                         input logic [ADDR_W-1:0] addr, input logic we,
                         input logic [DATA_W-1:0] wd,
                         input logic [DATA_W:0] a, input logic [DATA_W:0] b);
    logic              sa, sb, ea, eb, fat, in_cyc, exp_rd, exp_wr, first_wr;
    logic [DATA_W-1:0] sel, wdat;
    logic [3:0]        exp_pair;
    logic [DATA_W:0]   exp_mw;
    sa = dup || (mod[0] == 1'b0);
    sb = dup || (mod[0] == 1'b1);
    ea = sa && !is_good(a);
    eb = sb && !is_good(b);
    if (dup) begin
      if (is_good(a))      sel = a[DATA_W-1:0];
      else if (is_good(b)) sel = b[DATA_W-1:0];
      else                 sel = a[DATA_W-1:0];
      fat = !is_good(a) && !is_good(b);
    end else begin
      sel = mod[0] ? b[DATA_W-1:0] : a[DATA_W-1:0];
      fat = mod[0] ? !is_good(b) : !is_good(a);
    end
    wdat     = we ? wd : sel;
    exp_mw   = mk_word(wdat, 1'b0);
    exp_pair = 4'b0001 << mod[2:1];

    mrda = a;
    mrdb = b;
    if (is_i) begin
      ireq = 1'b1; imod = mod; iduplex = dup; iaddr = addr;
    end else begin
      dreq = 1'b1; dmod = mod; dduplex = dup; daddr = addr; dwe = we; dwdata = wd;
    end

    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      in_cyc   = (k <= LAT);
      exp_rd   = (k >= 2) && (k <= 1 + READ_CYC);
      exp_wr   = (k >= 2 + READ_CYC) && (k <= 1 + READ_CYC + WRITE_CYC);
      first_wr = (k == 2 + READ_CYC);
      check("mpair", 32'(mpair), 32'(in_cyc ? exp_pair : 4'b0000));
      check("msela", 32'(msela), 32'(in_cyc && sa));
      check("mselb", 32'(mselb), 32'(in_cyc && sb));
      check("maddr", 32'(maddr), 32'(in_cyc ? addr : '0));
      check("mrd", 32'(mrd), 32'(exp_rd));
      check("mwr", 32'(mwr), 32'(exp_wr));
      if (exp_wr) check("mwdata", 32'(mwdata), 32'(exp_mw));
      if (first_wr) m_fatal = m_fatal || fat;
      check("erra", 32'(erra), 32'(first_wr && ea));
      check("errb", 32'(errb), 32'(first_wr && eb));
      check("fatal", 32'(fatal), 32'(m_fatal));
      check("iack", 32'(iack), 32'(is_i && (k == LAT)));
      check("dack", 32'(dack), 32'(!is_i && (k == LAT)));
      if (k == LAT) begin
        if (!we) m_rdata = sel;
        check("rdata", 32'(rdata), 32'(m_rdata));
        ireq = 1'b0;
        dreq = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    ireq  = 1'b0;
    dreq  = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    m_rdata = '0;
    m_fatal = 1'b0;
    check("rst_mpair", 32'(mpair), 32'h0);
    check("rst_strobes", 32'({mrd, mwr, msela, mselb}), 32'h0);
    check("rst_acks", 32'({iack, dack, erra, errb}), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_fatal", 32'(fatal), 32'h0);
    check("rst_maddr", 32'(maddr), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    logic              r_is_i, r_dup, r_we;
    logic [2:0]        r_mod;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wd;
    logic [DATA_W:0]   r_a, r_b;
    logic [3:0]        exp_pair;
    int                n;

    ireq = 0; iduplex = 0; imod = '0; iaddr = '0;
    dreq = 0; dduplex = 0; dmod = '0; daddr = '0; dwe = 0; dwdata = '0;
    mrda = '0; mrdb = '0; reset = 1'b1;
    m_rdata = '0; m_fatal = 1'b0;
    @(negedge clk);
    apply_reset();

    // Instruction read, simplex side B; side A carries junk that must be ignored.
    run_txn(1'b1, 3'b101, 1'b0, 12'h2A5, 1'b0, '0,
            mk_word(26'h155AA33, 1'b1), mk_word(26'h0ABCDEF, 1'b0));

    // Duplex data read with side A parity broken: B is returned and scrubbed.
    run_txn(1'b0, 3'b000, 1'b1, 12'h031, 1'b0, '0,
            mk_word(26'h2222222, 1'b1), mk_word(26'h1234567, 1'b0));

    // Store of 26 ones: parity bit must be 1, RDATA keeps the previous read.
    run_txn(1'b0, 3'b011, 1'b0, 12'h7FF, 1'b1, 26'h3FFFFFF,
            mk_word(26'h0000001, 1'b0), mk_word(26'h0000010, 1'b0));

    // Duplex with both sides bad, then a clean cycle: FATAL stays set.
    run_txn(1'b1, 3'b110, 1'b1, 12'h100, 1'b0, '0,
            mk_word(26'h0F0F0F0, 1'b1), mk_word(26'h3030303, 1'b1));
    run_txn(1'b1, 3'b010, 1'b0, 12'h101, 1'b0, '0,
            mk_word(26'h0000777, 1'b0), mk_word(26'h0000888, 1'b0));

    for (int i = 0; i < 24; i++) begin
      r_is_i = 1'($urandom_range(0, 1));
      r_mod  = 3'($urandom_range(0, 7));
      r_dup  = 1'($urandom_range(0, 1));
      r_addr = ADDR_W'($urandom);
      r_we   = !r_is_i && ($urandom_range(0, 2) == 0);
      r_wd   = DATA_W'($urandom);
      r_a    = mk_word(DATA_W'($urandom), $urandom_range(0, 3) == 0);
      r_b    = mk_word(DATA_W'($urandom), $urandom_range(0, 3) == 0);
      run_txn(r_is_i, r_mod, r_dup, r_addr, r_we, r_wd, r_a, r_b);
    end

    // Reset during READ aborts the cycle with no ACK.
    mrda = mk_word(26'h0001234, 1'b0);
    mrdb = mk_word(26'h0005678, 1'b0);
    ireq = 1'b1; imod = 3'b010; iduplex = 1'b0; iaddr = 12'h0AA;
    repeat (2) @(negedge clk);
    check("mid_mrd_before", 32'(mrd), 32'h1);
    reset = 1'b1;
    ireq  = 1'b0;
    @(negedge clk);
    m_rdata = '0;
    m_fatal = 1'b0;
    check("mid_strobes", 32'({mrd, mwr, msela, mselb}), 32'h0);
    check("mid_mpair", 32'(mpair), 32'h0);
    check("mid_fatal", 32'(fatal), 32'h0);
    check("mid_rdata", 32'(rdata), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      check("mid_no_ack", 32'({iack, dack}), 32'h0);
      check("mid_idle_pair", 32'(mpair), 32'h0);
    end
    run_txn(1'b1, 3'b001, 1'b0, 12'h0AB, 1'b0, '0,
            mk_word(26'h0000ABC, 1'b0), mk_word(26'h0000DEF, 1'b0));

    // Both requesters held from reset: grants alternate I, D, I, D.
    apply_reset();
    mrda = mk_word(26'h0101010, 1'b0);
    mrdb = mk_word(26'h0202020, 1'b0);
    ireq = 1'b1; imod = 3'b000; iduplex = 1'b0; iaddr = 12'h001;
    dreq = 1'b1; dmod = 3'b110; dduplex = 1'b0; daddr = 12'h002; dwe = 1'b0;
    for (int c = 1; c <= 4 * PERIOD; c++) begin
      @(negedge clk);
      n        = c / PERIOD;
      exp_pair = ((c % PERIOD) == 0) ? 4'b0000 : (((n % 2) == 0) ? 4'b0001 : 4'b1000);
      check("arb_iack", 32'(iack), 32'(((c % PERIOD) == LAT) && ((n % 2) == 0)));
      check("arb_dack", 32'(dack), 32'(((c % PERIOD) == LAT) && ((n % 2) == 1)));
      check("arb_mpair", 32'(mpair), 32'(exp_pair));
      check("arb_rd_wr_excl", 32'(mrd && mwr), 32'h0);
      if (c == 4 * PERIOD - 1) begin
        ireq = 1'b0;
        dreq = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
